// File: rtl/ddr3_arb_pkg.sv
// ddr3_arb_pkg: shared definitions for the DDR3 front-end arbiter.
//   STATE_W   : width of the arbiter FSM state
//   IDX_W     : width of a requester index (up to 4 requesters)
//   DEAD_DATA : read data returned on an aborted transaction
//   state_e   : FSM encoding (IDLE=0, BUSY=1, ACK=2)
//   rr_index  : helper for round-robin index arithmetic
package ddr3_arb_pkg;

  localparam int unsigned STATE_W = 2;
  localparam int unsigned IDX_W = 2;
  localparam logic [31:0] DEAD_DATA = 32'hDEAD_BEEF;

  typedef enum logic [STATE_W-1:0] {
    StIdle = 2'd0,
    StBusy = 2'd1,
    StAck  = 2'd2
  } state_e;

  // Index 'step' places after 'base', wrapping at 'n'.
  function automatic logic [IDX_W-1:0] rr_index(input logic [IDX_W-1:0] base,
                                                  input int unsigned step,
                                                  input int unsigned n);
    return IDX_W'((32'(base) + step) % n);
  endfunction

endpackage

// File: rtl/ddr3_rr_picker.sv
// ddr3_rr_picker: combinational round-robin winner selection.
//   req_i        : per-requester request bits
//   last_grant_i : index granted most recently; search starts one past it
//   valid_o      : at least one request is present
//   winner_o     : index of the selected requester
module ddr3_rr_picker
  import ddr3_arb_pkg::*;
#(
  parameter int unsigned NumReq = 3
) (
  input  logic [NumReq-1:0] req_i,
  input  logic [IDX_W-1:0]  last_grant_i,
  output logic              valid_o,
  output logic [IDX_W-1:0]  winner_o
);

  // Padded so a 2-bit index is always in range, whatever NumReq is.
  logic [3:0] req_pad;
  assign req_pad = 4'(req_i);

  // Walk from the farthest candidate to the nearest; the last hit wins, which
  // is the nearest requester after last_grant_i.
  always_comb begin
    valid_o  = 1'b0;
    winner_o = '0;
    for (int unsigned i = NumReq; i >= 1; i--) begin
      if (req_pad[rr_index(last_grant_i, i, NumReq)]) begin
        valid_o  = 1'b1;
        winner_o = rr_index(last_grant_i, i, NumReq);
      end
    end
  end

endmodule

// File: rtl/ddr3_arbiter.sv
// ddr3_arbiter: round-robin arbiter placing NUM_REQ requesters onto one
// DDR3 cache controller port, one transaction at a time.
//   clk, rst             : clock, synchronous active-high reset
//   m_addr_i, m_data_i   : per-requester address / write data (32 bits each)
//   m_we_i, m_rd_i       : per-requester strobes, held until m_ack_o
//   m_data_o             : read data, valid with the requester's ack
//   m_ack_o, m_err_o     : one-cycle completion / timeout pulses
//   addr_o, data_o       : downstream address / write data
//   we_o, rd_o           : downstream strobes, held until ack_i
//   data_i, ack_i        : downstream read data / completion
//   state_value          : debug {grant[3:0], 10'b0, state[1:0]}
// Build option: define DDR3_ARB_TIMEOUT_EN to abort a BUSY transaction after
// TIMEOUT_CYCLES cycles with m_err_o and DEAD_DATA; otherwise BUSY waits forever.
module ddr3_arbiter
  import ddr3_arb_pkg::*;
#(
  parameter int unsigned NUM_REQ = 3,
  parameter int unsigned TIMEOUT_CYCLES = 4096
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [32*NUM_REQ-1:0] m_addr_i,
  input  logic [32*NUM_REQ-1:0] m_data_i,
  input  logic [NUM_REQ-1:0]    m_we_i,
  input  logic [NUM_REQ-1:0]    m_rd_i,
  output logic [31:0]           m_data_o,
  output logic [NUM_REQ-1:0]    m_ack_o,
  output logic [NUM_REQ-1:0]    m_err_o,
  output logic [31:0]           addr_o,
  output logic [31:0]           data_o,
  output logic                  we_o,
  output logic                  rd_o,
  input  logic [31:0]           data_i,
  input  logic                  ack_i,
  output logic [15:0]           state_value
);

  if (NUM_REQ < 2 || NUM_REQ > 4 || TIMEOUT_CYCLES < 2) begin : g_bad_param
    $error("ddr3_arbiter: NUM_REQ must be 2..4 and TIMEOUT_CYCLES at least 2");
  end

  state_e             state_q, state_d;
  logic [IDX_W-1:0]   grant_q, grant_d;
  logic [IDX_W-1:0]   last_grant_q, last_grant_d;
  logic [31:0]        addr_q, addr_d;
  logic [31:0]        data_q, data_d;
  logic [31:0]        rdata_q, rdata_d;
  logic               we_q, we_d;
  logic               rd_q, rd_d;

  logic [NUM_REQ-1:0] req;
  logic               pick_valid;
  logic [IDX_W-1:0]   pick_idx;
  logic [31:0]        sel_addr, sel_data;
  logic               sel_we, sel_rd;

  assign req = m_we_i | m_rd_i;

  ddr3_rr_picker #(
    .NumReq(NUM_REQ)
  ) u_picker (
    .req_i       (req),
    .last_grant_i(last_grant_q),
    .valid_o     (pick_valid),
    .winner_o    (pick_idx)
  );

  // Mux out the winning requester's fields.
  always_comb begin
    sel_addr = '0;
    sel_data = '0;
    sel_we   = 1'b0;
    sel_rd   = 1'b0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      if (pick_idx == IDX_W'(k)) begin
        sel_addr = m_addr_i[32*k +: 32];
        sel_data = m_data_i[32*k +: 32];
        sel_we   = m_we_i[k];
        sel_rd   = m_rd_i[k];
      end
    end
  end

`ifdef DDR3_ARB_TIMEOUT_EN
  logic [31:0] cnt_q, cnt_d;
  logic        err_q, err_d;
`endif

  always_comb begin
    state_d      = state_q;
    grant_d      = grant_q;
    last_grant_d = last_grant_q;
    addr_d       = addr_q;
    data_d       = data_q;
    rdata_d      = rdata_q;
    we_d         = we_q;
    rd_d         = rd_q;
`ifdef DDR3_ARB_TIMEOUT_EN
    cnt_d        = cnt_q;
    err_d        = err_q;
`endif
    unique case (state_q)
      StIdle: begin
        if (pick_valid) begin
          state_d      = StBusy;
          grant_d      = pick_idx;
          last_grant_d = pick_idx;
          addr_d       = sel_addr;
          data_d       = sel_data;
          we_d         = sel_we;
          // A simultaneous we+rd is treated as a write.
          rd_d         = sel_rd & ~sel_we;
`ifdef DDR3_ARB_TIMEOUT_EN
          cnt_d        = '0;
          err_d        = 1'b0;
`endif
        end
      end
      StBusy: begin
        // ack_i takes priority over a timeout landing in the same cycle.
        if (ack_i) begin
          state_d = StAck;
          rdata_d = data_i;
          we_d    = 1'b0;
          rd_d    = 1'b0;
        end
`ifdef DDR3_ARB_TIMEOUT_EN
        else if (cnt_q == 32'(TIMEOUT_CYCLES - 1)) begin
          state_d = StAck;
          rdata_d = DEAD_DATA;
          we_d    = 1'b0;
          rd_d    = 1'b0;
          err_d   = 1'b1;
        end else begin
          cnt_d = cnt_q + 32'd1;
        end
`endif
      end
      StAck: begin
        state_d = StIdle;
`ifdef DDR3_ARB_TIMEOUT_EN
        err_d   = 1'b0;
`endif
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= StIdle;
      grant_q      <= '0;
      last_grant_q <= IDX_W'(NUM_REQ - 1);
      addr_q       <= '0;
      data_q       <= '0;
      rdata_q      <= '0;
      we_q         <= 1'b0;
      rd_q         <= 1'b0;
    end else begin
      state_q      <= state_d;
      grant_q      <= grant_d;
      last_grant_q <= last_grant_d;
      addr_q       <= addr_d;
      data_q       <= data_d;
      rdata_q      <= rdata_d;
      we_q         <= we_d;
      rd_q         <= rd_d;
    end
  end

`ifdef DDR3_ARB_TIMEOUT_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
      err_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      err_q <= err_d;
    end
  end
`endif

  always_comb begin
    m_ack_o = '0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      m_ack_o[k] = (state_q == StAck) && (grant_q == IDX_W'(k));
    end
  end

`ifdef DDR3_ARB_TIMEOUT_EN
  assign m_err_o = err_q ? m_ack_o : '0;
`else
  assign m_err_o = '0;
`endif

  assign m_data_o    = rdata_q;
  assign addr_o      = addr_q;
  assign data_o      = data_q;
  assign we_o        = we_q;
  assign rd_o        = rd_q;
  assign state_value = {2'b00, grant_q, 10'b0, state_q};

endmodule

// File: tb/tb_ddr3_arbiter.sv
// tb_ddr3_arbiter: self-checking bench for ddr3_arbiter (NUM_REQ=3).
// Directed scenarios plus a randomized run scored against a transaction-level
// model of the round-robin rules. Timeout checks follow DDR3_ARB_TIMEOUT_EN.
module tb_ddr3_arbiter;

  localparam int unsigned N = 3;
`ifdef DDR3_ARB_TIMEOUT_EN
  localparam int unsigned TO = 16;
`else
  localparam int unsigned TO = 4096;
`endif

  logic           clk;
  logic           rst;
  logic [32*N-1:0] m_addr_i, m_data_i;
  logic [N-1:0]   m_we_i, m_rd_i, m_ack_o, m_err_o;
  logic [31:0]    m_data_o, addr_o, data_o, data_i;
  logic           we_o, rd_o, ack_i;
  logic [15:0]    state_value;

  ddr3_arbiter #(
    .NUM_REQ       (N),
    .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .m_addr_i   (m_addr_i),
    .m_data_i   (m_data_i),
    .m_we_i     (m_we_i),
    .m_rd_i     (m_rd_i),
    .m_data_o   (m_data_o),
    .m_ack_o    (m_ack_o),
    .m_err_o    (m_err_o),
    .addr_o     (addr_o),
    .data_o     (data_o),
    .we_o       (we_o),
    .rd_o       (rd_o),
    .data_i     (data_i),
    .ack_i      (ack_i),
    .state_value(state_value)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int n_cmp = 0;
  int n_bad = 0;

  // Transaction-level model: phase 0 = no transaction, 1 = outstanding
  // downstream, 2 = completion pulse due.
  int          phase, model_last, exp_k, exp_grant, busy_n, lat;
  logic [31:0] exp_addr, exp_data, exp_rdata;
  logic        exp_we, exp_rd;
  bit [N-1:0]  outstanding;
  int          grant_log[$];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    m_addr_i = '0;
    m_data_i = '0;
    m_we_i   = '0;
    m_rd_i   = '0;
    data_i   = '0;
    ack_i    = 1'b0;
  endtask

  task automatic set_req(input int k, input logic we, input logic rd,
                         input logic [31:0] addr, input logic [31:0] data);
    m_we_i[k] = we;
    m_rd_i[k] = rd;
    m_addr_i[32*k +: 32] = addr;
    m_data_i[32*k +: 32] = data;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    phase       = 0;
    model_last  = N - 1;
    exp_grant   = 0;
    exp_rdata   = '0;
    outstanding = '0;
    grant_log.delete();
  endtask

  // First requester at or after last+1 (mod N) that is asking.
  function automatic int rr_pick(input bit [N-1:0] req, input int last);
    for (int i = 1; i <= int'(N); i++) begin
      int k;
      k = (last + i) % int'(N);
      if (req[k]) return k;
    end
    return -1;
  endfunction

  // Cycle-by-cycle run: random requesters and a random-latency downstream,
  // every output compared against the model each cycle.
  task automatic run_engine(input int cycles, input bit saturate);
    logic [32*N-1:0] s_addr, s_data;
    logic [N-1:0]    s_req, s_we, s_rd, onehot, one;
    logic            s_ack;
    logic [31:0]     s_din;
    int              k, r;
    one = 1;
    for (int c = 0; c < cycles; c++) begin
      s_addr = m_addr_i;
      s_data = m_data_i;
      s_we   = m_we_i;
      s_rd   = m_rd_i;
      s_req  = m_we_i | m_rd_i;
      s_ack  = ack_i;
      s_din  = data_i;
      tick();
      case (phase)
        0: if (s_req != 0) begin
          k          = rr_pick(s_req, model_last);
          model_last = k;
          exp_k      = k;
          exp_grant  = k;
          exp_addr   = s_addr[32*k +: 32];
          exp_data   = s_data[32*k +: 32];
          exp_we     = s_we[k];
          exp_rd     = s_rd[k] & ~s_we[k];
          busy_n     = 0;
          lat        = $urandom_range(1, 8);
          phase      = 1;
          grant_log.push_back(k);
        end
        1: if (s_ack) begin
          exp_rdata = s_din;
          phase     = 2;
        end
        default: phase = 0;
      endcase

      n_cmp++;
      if (phase == 1) begin
        busy_n++;
        if ({addr_o, data_o, we_o, rd_o, m_ack_o, m_err_o, state_value} !==
            {exp_addr, exp_data, exp_we, exp_rd, {N{1'b0}}, {N{1'b0}},
             4'(exp_k), 10'b0, 2'd1}) begin
          n_bad++;
          $display("FAIL busy_outputs c=%0d: got addr=%h data=%h we=%b rd=%b ack=%b err=%b sv=%h want addr=%h data=%h we=%b rd=%b ack=0 err=0 grant=%0d busy",
                   c, addr_o, data_o, we_o, rd_o, m_ack_o, m_err_o, state_value,
                   exp_addr, exp_data, exp_we, exp_rd, exp_k);
        end
      end else if (phase == 2) begin
        onehot = one << exp_k;
        if ({m_ack_o, m_err_o, m_data_o, we_o, rd_o, state_value} !==
            {onehot, {N{1'b0}}, exp_rdata, 2'b00, 4'(exp_k), 10'b0, 2'd2}) begin
          n_bad++;
          $display("FAIL ack_outputs c=%0d: got ack=%b err=%b rdata=%h we=%b rd=%b sv=%h want ack=%b err=0 rdata=%h strobes=0",
                   c, m_ack_o, m_err_o, m_data_o, we_o, rd_o, state_value,
                   onehot, exp_rdata);
        end
      end else begin
        if ({m_ack_o, m_err_o, we_o, rd_o, m_data_o, state_value} !==
            {{N{1'b0}}, {N{1'b0}}, 2'b00, exp_rdata, 4'(exp_grant), 10'b0, 2'd0}) begin
          n_bad++;
          $display("FAIL idle_outputs c=%0d: got ack=%b err=%b we=%b rd=%b rdata=%h sv=%h want all quiet rdata=%h grant=%0d",
                   c, m_ack_o, m_err_o, we_o, rd_o, m_data_o, state_value,
                   exp_rdata, exp_grant);
        end
      end

      // Downstream responder; spurious acks outside a transaction.
      data_i = $urandom();
      if (phase == 1) ack_i = (busy_n == lat);
      else            ack_i = ($urandom_range(0, 7) == 0);

      for (int j = 0; j < int'(N); j++) begin
        if (phase == 2 && j == exp_k) begin
          m_we_i[j] = 1'b0;
          m_rd_i[j] = 1'b0;
          outstanding[j] = 1'b0;
        end else if (!outstanding[j]) begin
          if (saturate || $urandom_range(0, 3) == 0) begin
            r = $urandom_range(0, 2);
            outstanding[j] = 1'b1;
            set_req(j, r != 0, r != 1, $urandom(), $urandom());
          end
        end else if (phase == 1 && j == exp_k && !saturate) begin
          // Owner of the latched transaction scribbles/drops its inputs.
          m_addr_i[32*j +: 32] = $urandom();
          m_data_i[32*j +: 32] = $urandom();
          if ($urandom_range(0, 9) == 0) begin
            m_we_i[j] = 1'b0;
            m_rd_i[j] = 1'b0;
          end
        end
      end
    end
    idle_inputs();
  endtask

  task automatic test_reset();
    do_reset();
    n_cmp++;
    if ({state_value, m_ack_o, m_err_o, we_o, rd_o} !== '0) begin
      n_bad++;
      $display("FAIL reset_ctrl: got sv=%h ack=%b err=%b we=%b rd=%b want all 0",
               state_value, m_ack_o, m_err_o, we_o, rd_o);
    end
    n_cmp++;
    if ({addr_o, data_o, m_data_o} !== 96'd0) begin
      n_bad++;
      $display("FAIL reset_data: got addr=%h data=%h rdata=%h want 0",
               addr_o, data_o, m_data_o);
    end
    ack_i  = 1'b1;
    data_i = 32'hFFFF_0000;
    tick();
    ack_i = 1'b0;
    tick();
    n_cmp++;
    if ({state_value, m_ack_o, m_data_o} !== '0) begin
      n_bad++;
      $display("FAIL idle_ack_ignored: got sv=%h ack=%b rdata=%h want 0",
               state_value, m_ack_o, m_data_o);
    end
  endtask

  task automatic test_single_read();
    int hi;
    bit done;
    logic [N-1:0] ack_val;
    logic [31:0] rd_val;
    logic strb;
    do_reset();
    hi = 0;
    done = 0;
    ack_val = '0;
    rd_val = '0;
    strb = 1'b1;
    set_req(1, 1'b0, 1'b1, 32'h100, 32'h0BAD_0BAD);
    for (int c = 0; c < 40 && !done; c++) begin
      tick();
      ack_i = 1'b0;
      if (m_ack_o != 0) begin
        done    = 1;
        ack_val = m_ack_o;
        rd_val  = m_data_o;
        strb    = we_o | rd_o;
        set_req(1, 1'b0, 1'b0, 32'h0, 32'h0);
      end else if (rd_o) begin
        hi++;
        if (hi == 1) begin
          n_cmp++;
          if (addr_o !== 32'h100 || we_o !== 1'b0) begin
            n_bad++;
            $display("FAIL read_addr: got addr=%h we=%b want addr=00000100 we=0", addr_o, we_o);
          end
        end
        if (hi == 5) begin
          ack_i  = 1'b1;
          data_i = 32'h1234_5678;
        end
      end
    end
    n_cmp++;
    if (!done || hi != 5 || ack_val !== 3'b010 || strb !== 1'b0) begin
      n_bad++;
      $display("FAIL read_ack: got done=%0d rd_cycles=%0d ack=%b strobes=%b want done=1 rd_cycles=5 ack=010 strobes=0",
               done, hi, ack_val, strb);
    end
    n_cmp++;
    if (rd_val !== 32'h1234_5678) begin
      n_bad++;
      $display("FAIL read_data: got %h want 12345678", rd_val);
    end
    tick();
    n_cmp++;
    if (m_ack_o !== 3'b000 || m_data_o !== 32'h1234_5678 || rd_o !== 1'b0) begin
      n_bad++;
      $display("FAIL read_after_ack: got ack=%b rdata=%h rd=%b want ack=000 rdata=12345678 rd=0",
               m_ack_o, m_data_o, rd_o);
    end
  endtask

  task automatic test_we_rd();
    do_reset();
    set_req(0, 1'b1, 1'b1, 32'h0000_2000, 32'hA5A5_A5A5);
    tick();
    n_cmp++;
    if ({we_o, rd_o} !== 2'b10 || data_o !== 32'hA5A5_A5A5 || addr_o !== 32'h0000_2000) begin
      n_bad++;
      $display("FAIL we_rd_latch: got we=%b rd=%b data=%h addr=%h want we=1 rd=0 data=a5a5a5a5 addr=00002000",
               we_o, rd_o, data_o, addr_o);
    end
    ack_i  = 1'b1;
    data_i = 32'h0000_0077;
    tick();
    ack_i = 1'b0;
    set_req(0, 1'b0, 1'b0, 32'h0, 32'h0);
    n_cmp++;
    if (m_ack_o !== 3'b001 || {we_o, rd_o} !== 2'b00) begin
      n_bad++;
      $display("FAIL we_rd_ack: got ack=%b we=%b rd=%b want ack=001 strobes=0",
               m_ack_o, we_o, rd_o);
    end
    tick();
  endtask

  task automatic test_timeout();
    int busy, acks;
    bit got;
    logic [N-1:0] ack_val, err_val;
    logic [31:0] rd_val;
    logic [31:0] resp;
    do_reset();
    busy = 0;
    acks = 0;
    got = 0;
    ack_val = '0;
    err_val = '0;
    rd_val = '0;
    resp = 32'h0C0F_FEE0;
`ifdef DDR3_ARB_TIMEOUT_EN
    set_req(0, 1'b0, 1'b1, 32'h300, 32'h0);
    for (int c = 0; c < 100 && !got; c++) begin
      tick();
      if (m_ack_o != 0) begin
        got = 1;
        ack_val = m_ack_o;
        err_val = m_err_o;
        rd_val  = m_data_o;
        set_req(0, 1'b0, 1'b0, 32'h0, 32'h0);
      end else if (rd_o) busy++;
    end
    n_cmp++;
    if (!got || busy != int'(TO) || ack_val !== 3'b001 || err_val !== 3'b001) begin
      n_bad++;
      $display("FAIL timeout_pulse: got done=%0d busy=%0d ack=%b err=%b want done=1 busy=%0d ack=001 err=001",
               got, busy, ack_val, err_val, TO);
    end
    n_cmp++;
    if (rd_val !== 32'hDEAD_BEEF) begin
      n_bad++;
      $display("FAIL timeout_data: got %h want deadbeef", rd_val);
    end
    tick();
    n_cmp++;
    if (m_err_o !== 3'b000 || m_ack_o !== 3'b000) begin
      n_bad++;
      $display("FAIL timeout_one_cycle: got ack=%b err=%b want 0", m_ack_o, m_err_o);
    end
    // ack_i on the last allowed cycle beats the timeout.
    busy = 0;
    got = 0;
    set_req(1, 1'b0, 1'b1, 32'h400, 32'h0);
    for (int c = 0; c < 100 && !got; c++) begin
      tick();
      ack_i = 1'b0;
      if (m_ack_o != 0) begin
        got = 1;
        ack_val = m_ack_o;
        err_val = m_err_o;
        rd_val  = m_data_o;
        set_req(1, 1'b0, 1'b0, 32'h0, 32'h0);
      end else if (rd_o) begin
        busy++;
        if (busy == int'(TO)) begin
          ack_i  = 1'b1;
          data_i = resp;
        end
      end
    end
    n_cmp++;
    if (!got || ack_val !== 3'b010 || err_val !== 3'b000 || rd_val !== resp) begin
      n_bad++;
      $display("FAIL timeout_ack_wins: got done=%0d ack=%b err=%b rdata=%h want done=1 ack=010 err=000 rdata=%h",
               got, ack_val, err_val, rd_val, resp);
    end
`else
    set_req(0, 1'b0, 1'b1, 32'h300, 32'h0);
    for (int c = 0; c < 40; c++) begin
      tick();
      if (rd_o) busy++;
      if (m_ack_o != 0 || m_err_o != 0) acks++;
    end
    n_cmp++;
    if (busy != 40 || acks != 0 || state_value[1:0] !== 2'd1) begin
      n_bad++;
      $display("FAIL no_timeout_hold: got busy=%0d acks=%0d state=%0d want busy=40 acks=0 state=1",
               busy, acks, state_value[1:0]);
    end
`endif
    do_reset();
  endtask

  task automatic test_reset_mid_busy();
    int busy, acks;
    do_reset();
    busy = 0;
    acks = 0;
    set_req(2, 1'b0, 1'b1, 32'h500, 32'h0);
    for (int c = 0; c < 20 && busy < 3; c++) begin
      tick();
      if (rd_o) busy++;
    end
    n_cmp++;
    if (busy != 3) begin
      n_bad++;
      $display("FAIL mid_busy_setup: got busy=%0d want 3", busy);
    end
    rst = 1'b1;
    set_req(2, 1'b0, 1'b0, 32'h0, 32'h0);
    tick();
    rst = 1'b0;
    n_cmp++;
    if ({we_o, rd_o} !== 2'b00 || state_value !== 16'h0000 || m_ack_o !== 3'b000) begin
      n_bad++;
      $display("FAIL mid_busy_reset: got we=%b rd=%b sv=%h ack=%b want 0",
               we_o, rd_o, state_value, m_ack_o);
    end
    for (int c = 0; c < 6; c++) begin
      tick();
      if (m_ack_o != 0) acks++;
    end
    n_cmp++;
    if (acks != 0) begin
      n_bad++;
      $display("FAIL mid_busy_no_ack: got acks=%0d want 0", acks);
    end
    set_req(0, 1'b0, 1'b1, 32'hA000, 32'h0);
    set_req(1, 1'b0, 1'b1, 32'hA001, 32'h0);
    set_req(2, 1'b0, 1'b1, 32'hA002, 32'h0);
    tick();
    n_cmp++;
    if (addr_o !== 32'hA000 || state_value !== 16'h0001) begin
      n_bad++;
      $display("FAIL mid_busy_regrant: got addr=%h sv=%h want addr=0000a000 sv=0001",
               addr_o, state_value);
    end
    do_reset();
  endtask

  task automatic test_contention();
    do_reset();
    run_engine(80, 1'b1);
    n_cmp++;
    if (grant_log.size() < 9) begin
      n_bad++;
      $display("FAIL contention_count: got grants=%0d want >=9", grant_log.size());
    end
    for (int i = 0; i < grant_log.size() && i < 9; i++) begin
      n_cmp++;
      if (grant_log[i] != i % int'(N)) begin
        n_bad++;
        $display("FAIL contention_order[%0d]: got %0d want %0d", i, grant_log[i], i % int'(N));
      end
    end
  endtask

  task automatic test_random();
    do_reset();
    run_engine(1500, 1'b0);
    n_cmp++;
    if (grant_log.size() < 50) begin
      n_bad++;
      $display("FAIL random_progress: got grants=%0d want >=50", grant_log.size());
    end
  endtask

  initial begin
    test_reset();
    test_single_read();
    test_we_rd();
    test_timeout();
    test_reset_mid_busy();
    test_contention();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/ddr3_arbiter.md
DDR3_ARBITER -- requirements
Module: ddr3_arbiter

Interface
REQ-001 Parameter: NUM_REQ, 3, number of requesters; legal values are 2..4.
REQ-002 Parameter: TIMEOUT_CYCLES, 4096, BUSY cycles allowed before abort (used only with DDR3_ARB_TIMEOUT_EN).
REQ-003 Port: clk  in  1  system clock; the only clock of the block.
REQ-004 Port: rst  in  1  synchronous reset, active-high.
REQ-005 Port: m_addr_i  in  32*NUM_REQ  per-requester byte address; slice k is [32k+31:32k].
REQ-006 Port: m_data_i  in  32*NUM_REQ  per-requester write data.
REQ-007 Port: m_we_i / m_rd_i  in  NUM_REQ each  per-requester write/read strobe; held high until ack.
REQ-008 Port: m_data_o  out  32  read data, shared by all requesters; valid only with the requester's ack.
REQ-009 Port: m_ack_o  out  NUM_REQ  one-cycle completion pulse per requester.
REQ-010 Port: m_err_o  out  NUM_REQ  one-cycle timeout pulse, coincident with m_ack_o.
REQ-011 Port: addr_o, data_o  out  32 each  downstream address and write data to the DDR3 cache controller.
REQ-012 Port: we_o, rd_o  out  1 each  downstream strobes; level-held until ack_i.
REQ-013 Port: data_i  in  32  downstream read data; ack_i  in  1  downstream completion.
REQ-014 Port: state_value  out  16  debug: {grant index[3:0], 10'b0, state[1:0]}.

Function
REQ-015 FSM states: IDLE, BUSY and ACK, with a 2-bit encoding of IDLE=0, BUSY=1, ACK=2.
REQ-016 In IDLE, req[k] = m_we_i[k] | m_rd_i[k]; with any req set, pick a winner round-robin starting at last_grant+1 mod NUM_REQ, register it as grant and last_grant, latch its addr/data/we/rd into output registers, and go to BUSY.
REQ-017 When a requester asserts we and rd together, the latched request is a write (we_o=1, rd_o=0).
REQ-018 In BUSY, addr_o/data_o/we_o/rd_o stay constant; on ack_i=1, register data_i into m_data_o, clear we_o/rd_o, and go to ACK.
REQ-019 In ACK, m_ack_o[grant]=1 for exactly one cycle, downstream strobes are 0, and the next state is IDLE unconditionally.
REQ-020 Requesters deassert their strobes at the edge ending ACK; consequently the earliest re-grant is 1 cycle after ACK, and minimum round trip is grant edge + downstream latency + 2 cycles.
REQ-021 ack_i seen outside BUSY is ignored.
REQ-022 Changes on m_* inputs during BUSY/ACK do not affect the outstanding transaction.
REQ-023 A requester dropping its strobe before ack still completes the transaction; its ack pulse is issued anyway.
REQ-024 With all requesters asserting continuously, grants rotate 0,1,...,NUM_REQ-1,0; no requester waits more than NUM_REQ-1 transactions.
REQ-025 m_data_o holds its last value outside ACK; m_ack_o and m_err_o are 0 outside ACK.

Reset
REQ-026 On rst=1 at a clock edge: state=IDLE, last_grant=NUM_REQ-1 (requester 0 wins first), grant=0, we_o=rd_o=0, addr_o=data_o=m_data_o=0, m_ack_o=m_err_o=0, timeout counter=0.
REQ-027 Reset mid-BUSY abandons the transaction with no ack issued; downstream is reset by the same rst.

Configuration
REQ-028 Macro DDR3_ARB_TIMEOUT_EN defined: a counter clears on entering BUSY and increments each BUSY cycle.
REQ-029 With DDR3_ARB_TIMEOUT_EN, when the counter reaches TIMEOUT_CYCLES-1 without ack_i, the block clears the strobes, loads m_data_o=32'hDEAD_BEEF, goes to ACK, and pulses both m_ack_o[grant] and m_err_o[grant].
REQ-030 With DDR3_ARB_TIMEOUT_EN, ack_i arriving in that same cycle wins, and the transaction completes normally with no err.
REQ-031 Macro undefined: no counter is built, m_err_o is tied to 0, and BUSY waits indefinitely.

Structure
REQ-032 Package ddr3_arb_pkg holds the state enum/encoding, the DEAD_DATA constant 32'hDEAD_BEEF and the STATE_W=2 width.
REQ-033 Sub-module ddr3_rr_picker is purely combinational: inputs req[NUM_REQ] and last_grant, outputs valid and winner index.

Verification
REQ-034 Single read: m1 rd, addr=0x100, downstream acks after 5 cycles with 0x12345678 -> rd_o high for 5 cycles, m_ack_o=3'b010 for one cycle, m_data_o=0x12345678.
REQ-035 Contention: all three requesters assert from reset -> grant order 0,1,2,0; each ack pulses once; no overlapping strobes.
REQ-036 we and rd together: m0 we+rd, data 0xA5A5A5A5 -> we_o=1, rd_o=0, data_o=0xA5A5A5A5.
REQ-037 Timeout (macro on, TIMEOUT_CYCLES=16): ack_i never arrives -> after 16 BUSY cycles, m_ack_o and m_err_o pulse together and m_data_o=0xDEADBEEF; with the macro off, the block stays in BUSY.
REQ-038 Reset mid-BUSY: assert rst 3 cycles into BUSY -> the next cycle shows we_o=rd_o=0 and state_value=0, no ack issued, and requester 0 wins next.
